// File: rtl/mmu_pkg.sv
// Shared types and defaults for the systolic-array MMU controller.
package mmu_pkg;

    localparam int unsigned MMU_DATA_WIDTH = 16;
    localparam int unsigned MMU_ARRAY_DIM  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        SETTLE = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } mmu_state_t;

    // Handshake/status flags {cmd_ready, wt_ready, act_ready, busy} held while in a state.
    function automatic logic [3:0] state_flags(input mmu_state_t s);
        return {s == IDLE, s == LOAD_W, s == STREAM, s != IDLE};
    endfunction

endpackage

// File: rtl/mmu_skew.sv
// Per-row activation delay line: DEPTH+1 register stages carrying data and its enable.
module mmu_skew #(
    parameter int DEPTH      = 0,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_en
);

    logic [DATA_WIDTH-1:0] data_q [DEPTH+1];
    logic                  en_q   [DEPTH+1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i <= DEPTH; i++) begin
                data_q[i] <= '0;
                en_q[i]   <= 1'b0;
            end
        end else begin
            data_q[0] <= in_data;
            en_q[0]   <= in_en;
            for (int i = 1; i <= DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
                en_q[i]   <= en_q[i-1];
            end
        end
    end

    assign out_data = data_q[DEPTH];
    assign out_en   = en_q[DEPTH];

endmodule

// File: rtl/mmu_ctrl.sv
// Weight-stationary systolic array controller: loads weights, settles, streams skewed
// activations, drains the array and pulses done.
module mmu_ctrl
    import mmu_pkg::*;
#(
    parameter int DATA_WIDTH = MMU_DATA_WIDTH,
    parameter int ARRAY_DIM  = MMU_ARRAY_DIM,
    parameter int ROW_CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [ROW_CNT_W-1:0]            cmd_num_rows,
    input  logic                            wt_valid,
    output logic                            wt_ready,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0] wt_data,
    input  logic                            act_valid,
    output logic                            act_ready,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0] act_data,
    output logic [ARRAY_DIM-1:0]            arr_w_wen,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] arr_w_data,
    output logic [ARRAY_DIM-1:0]            arr_en,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] arr_act,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned PH_W = $clog2(2 * ARRAY_DIM) + 1;
    localparam logic [PH_W-1:0] LAST_BEAT  = PH_W'(ARRAY_DIM - 1);
    localparam logic [PH_W-1:0] LAST_DRAIN = PH_W'(2 * ARRAY_DIM - 2);

    mmu_state_t           state;
    logic [ROW_CNT_W-1:0] num_rows;
    logic [ROW_CNT_W-1:0] row_cnt;
    logic [PH_W-1:0]      ph_cnt;
    logic                 cmd_fire;
    logic                 wt_fire;
    logic                 act_fire;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign wt_fire  = wt_valid & wt_ready;
    assign act_fire = act_valid & act_ready;

    // ph_cnt counts weight beats in LOAD_W and elapsed cycles in SETTLE and DRAIN.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            {cmd_ready, wt_ready, act_ready, busy} <= state_flags(IDLE);
            num_rows   <= '0;
            row_cnt    <= '0;
            ph_cnt     <= '0;
            done       <= 1'b0;
            arr_w_wen  <= '0;
            arr_w_data <= '0;
        end else begin
            done       <= 1'b0;
            arr_w_wen  <= {ARRAY_DIM{wt_fire}};
            arr_w_data <= wt_fire ? wt_data : '0;
            case (state)
                IDLE: if (cmd_fire) begin
                    num_rows <= cmd_num_rows;
                    row_cnt  <= '0;
                    ph_cnt   <= '0;
                    state    <= LOAD_W;
                    {cmd_ready, wt_ready, act_ready, busy} <= state_flags(LOAD_W);
                end
                LOAD_W: if (wt_fire) begin
                    if (ph_cnt == LAST_BEAT) begin
                        ph_cnt <= '0;
                        state  <= SETTLE;
                        {cmd_ready, wt_ready, act_ready, busy} <= state_flags(SETTLE);
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                SETTLE: begin
                    if (ph_cnt == LAST_BEAT) begin
                        ph_cnt <= '0;
                        if (num_rows != '0) begin
                            state <= STREAM;
                            {cmd_ready, wt_ready, act_ready, busy} <= state_flags(STREAM);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            {cmd_ready, wt_ready, act_ready, busy} <= state_flags(DONE);
                        end
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                STREAM: if (act_fire) begin
                    row_cnt <= row_cnt + ROW_CNT_W'(1);
                    if (row_cnt == num_rows - ROW_CNT_W'(1)) begin
                        state <= DRAIN;
                        {cmd_ready, wt_ready, act_ready, busy} <= state_flags(DRAIN);
                    end
                end
                DRAIN: begin
                    if (ph_cnt == LAST_DRAIN) begin
                        ph_cnt <= '0;
                        state  <= DONE;
                        done   <= 1'b1;
                        {cmd_ready, wt_ready, act_ready, busy} <= state_flags(DONE);
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    {cmd_ready, wt_ready, act_ready, busy} <= state_flags(IDLE);
                end
                default: begin
                    state <= IDLE;
                    {cmd_ready, wt_ready, act_ready, busy} <= state_flags(IDLE);
                end
            endcase
        end
    end

    // Row r of the left edge sees its element r cycles after row 0; bubbles carry zero data.
    for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_row
        logic [DATA_WIDTH-1:0] row_in;
        assign row_in = act_fire ? act_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;

        mmu_skew #(
            .DEPTH      (r),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_skew (
            .clk      (clk),
            .rstn     (rstn),
            .in_data  (row_in),
            .in_en    (act_fire),
            .out_data (arr_act[r*DATA_WIDTH +: DATA_WIDTH]),
            .out_en   (arr_en[r])
        );
    end

endmodule

// File: tb/tb_mmu_ctrl.sv
// Directed self-checking bench for mmu_ctrl with default parameters.
module tb_mmu_ctrl;

    localparam int unsigned DW  = 16;
    localparam int unsigned DIM = 4;
    localparam int unsigned RW  = 16;
    localparam int unsigned VW  = DW * DIM;

    logic          clk;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [RW-1:0] cmd_num_rows;
    logic          wt_valid;
    logic          wt_ready;
    logic [VW-1:0] wt_data;
    logic          act_valid;
    logic          act_ready;
    logic [VW-1:0] act_data;
    logic [DIM-1:0] arr_w_wen;
    logic [VW-1:0] arr_w_data;
    logic [DIM-1:0] arr_en;
    logic [VW-1:0] arr_act;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    mmu_ctrl #(
        .DATA_WIDTH (DW),
        .ARRAY_DIM  (DIM),
        .ROW_CNT_W  (RW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_num_rows (cmd_num_rows),
        .wt_valid     (wt_valid),
        .wt_ready     (wt_ready),
        .wt_data      (wt_data),
        .act_valid    (act_valid),
        .act_ready    (act_ready),
        .act_data     (act_data),
        .arr_w_wen    (arr_w_wen),
        .arr_w_data   (arr_w_data),
        .arr_en       (arr_en),
        .arr_act      (arr_act),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [VW-1:0] wt_pat(input int b);
        logic [VW-1:0] v;
        for (int c = 0; c < DIM; c++) v[c*DW +: DW] = DW'(40960 + 16 * c + b + 1);
        return v;
    endfunction

    function automatic logic [VW-1:0] act_pat(input int k);
        logic [VW-1:0] v;
        for (int r = 0; r < DIM; r++) v[r*DW +: DW] = DW'(4096 * (r + 1) + k);
        return v;
    endfunction

    // Full command: cmd handshake, weight load, settle, stream with optional gap, drain, done.
    task automatic run_command(input int rows, input bit wt_toggle, input int gap_at,
                               input int gap_len, input bit hold_cmd, input string tag);
        int beats;
        int acc;
        int last_k;
        int done_k;
        int en0_count;
        int j;
        bit wv;
        bit fired [64];
        bit valid_k [64];
        logic [VW-1:0] pat;
        logic [VW-1:0] exp_act;
        logic [DIM-1:0] exp_en;
        logic [3:0] exp_ctrl;

        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_ready: got %b want 1", tag, cmd_ready);
        end
        cmd_valid    = 1'b1;
        cmd_num_rows = RW'(rows);
        @(negedge clk);
        if (!hold_cmd) cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, wt_ready, busy} !== 3'b011) begin
            errors++;
            $display("FAIL %s_load_entry: got cmd/wt/busy=%b want 011", tag, {cmd_ready, wt_ready, busy});
        end

        beats = 0;
        for (int i = 0; i < 20 && beats < int'(DIM); i++) begin
            checks++;
            if (wt_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_wt_ready beat=%0d: got %b want 1", tag, beats, wt_ready);
            end
            wv       = wt_toggle ? (i % 2 == 0) : 1'b1;
            wt_valid = wv;
            wt_data  = wt_pat(beats);
            @(negedge clk);
            checks++;
            if (arr_w_wen !== (wv ? 4'hF : 4'h0) || arr_w_data !== (wv ? wt_pat(beats) : '0)) begin
                errors++;
                $display("FAIL %s_wt_write i=%0d: got wen=%h data=%h want wen=%h data=%h", tag, i,
                         arr_w_wen, arr_w_data, wv ? 4'hF : 4'h0, wv ? wt_pat(beats) : '0);
            end
            if (wv) beats++;
        end

        // Offer weights and activations during SETTLE; both must be ignored.
        wt_valid  = 1'b1;
        wt_data   = wt_pat(7);
        act_valid = 1'b1;
        act_data  = act_pat(50);
        for (int s = 1; s <= int'(DIM); s++) begin
            checks++;
            if (wt_ready !== 1'b0 || act_ready !== 1'b0 || arr_en !== '0 || busy !== 1'b1 ||
                (s > 1 && (arr_w_wen !== '0 || arr_w_data !== '0))) begin
                errors++;
                $display("FAIL %s_settle s=%0d: got wt_rdy=%b act_rdy=%b en=%b busy=%b wen=%h want 0 0 0 1 0",
                         tag, s, wt_ready, act_ready, arr_en, busy, arr_w_wen);
            end
            @(negedge clk);
        end
        wt_valid = 1'b0;

        if (rows == 0) begin
            act_valid = 1'b0;
            checks++;
            if ({done, busy, cmd_ready, act_ready} !== 4'b1100 || arr_en !== '0) begin
                errors++;
                $display("FAIL %s_zero_done: got done/busy/cmd/act=%b en=%b want 1100 en=0",
                         tag, {done, busy, cmd_ready, act_ready}, arr_en);
            end
            @(negedge clk);
            checks++;
            if ({done, busy, cmd_ready} !== 3'b001 || arr_en !== '0) begin
                errors++;
                $display("FAIL %s_zero_idle: got done/busy/cmd=%b en=%b want 001 en=0",
                         tag, {done, busy, cmd_ready}, arr_en);
            end
            return;
        end

        acc    = 0;
        last_k = 0;
        for (int k = 0; k < 64; k++) begin
            fired[k]   = 1'b0;
            valid_k[k] = !(gap_len > 0 && k >= gap_at && k < gap_at + gap_len);
            if (k >= 1 && valid_k[k] && acc < rows) begin
                fired[k] = 1'b1;
                acc++;
                last_k = k;
            end
        end
        done_k    = last_k + 2 * int'(DIM);
        en0_count = 0;

        for (int k = 1; k <= done_k + 1; k++) begin
            exp_en  = '0;
            exp_act = '0;
            for (int r = 0; r < int'(DIM); r++) begin
                j = k - 1 - r;
                if (j >= 1 && fired[j]) begin
                    exp_en[r] = 1'b1;
                    pat = act_pat(j);
                    exp_act[r*DW +: DW] = pat[r*DW +: DW];
                end
            end
            exp_ctrl = {k <= last_k, k == done_k, k <= done_k, k == done_k + 1};
            checks++;
            if (arr_en !== exp_en || arr_act !== exp_act) begin
                errors++;
                $display("FAIL %s_skew k=%0d: got en=%b act=%h want en=%b act=%h", tag, k,
                         arr_en, arr_act, exp_en, exp_act);
            end
            checks++;
            if ({act_ready, done, busy, cmd_ready} !== exp_ctrl) begin
                errors++;
                $display("FAIL %s_ctrl k=%0d: got act_rdy/done/busy/cmd_rdy=%b want %b", tag, k,
                         {act_ready, done, busy, cmd_ready}, exp_ctrl);
            end
            if (arr_en[0] === 1'b1) en0_count++;
            if (k <= done_k) begin
                act_valid = valid_k[k];
                act_data  = act_pat(k);
                @(negedge clk);
            end
        end
        act_valid = 1'b0;
        checks++;
        if (en0_count != rows) begin
            errors++;
            $display("FAIL %s_accepted: got %0d rows want %0d", tag, en0_count, rows);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cmd_valid = 1'b0;
        cmd_num_rows = '0;
        wt_valid = 1'b0;
        wt_data = '0;
        act_valid = 1'b0;
        act_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00 || arr_en !== '0 || arr_act !== '0 || arr_w_wen !== '0 || arr_w_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b en=%b act=%h wen=%h wdata=%h want all 0",
                     busy, done, arr_en, arr_act, arr_w_wen, arr_w_data);
        end
        rstn = 1'b1;
        wt_valid = 1'b1;
        wt_data = wt_pat(3);
        act_valid = 1'b1;
        act_data = act_pat(3);
        @(negedge clk);
        checks++;
        if ({cmd_ready, wt_ready, act_ready, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release: got cmd/wt/act/busy=%b want 1000", {cmd_ready, wt_ready, act_ready, busy});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (arr_w_wen !== '0 || arr_en !== '0 || arr_act !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got wen=%h en=%b act=%h busy=%b want 0", arr_w_wen, arr_en, arr_act, busy);
        end
        wt_valid = 1'b0;
        act_valid = 1'b0;
    endtask

    task automatic test_basic();
        run_command(3, 1'b0, 0, 0, 1'b0, "basic");
    endtask

    task automatic test_wt_gaps();
        run_command(2, 1'b1, 0, 0, 1'b0, "wtgap");
    endtask

    task automatic test_act_gap();
        run_command(5, 1'b0, 3, 2, 1'b0, "actgap");
    endtask

    task automatic test_zero_rows();
        run_command(0, 1'b0, 0, 0, 1'b0, "zero");
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1;
        cmd_num_rows = RW'(6);
        @(negedge clk);
        cmd_valid = 1'b0;
        wt_valid = 1'b1;
        wt_data = wt_pat(1);
        repeat (DIM) @(negedge clk);
        wt_valid = 1'b0;
        repeat (DIM) @(negedge clk);
        act_valid = 1'b1;
        act_data = act_pat(1);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || arr_en[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_streaming: got busy=%b en=%b want busy=1 en[0]=1", busy, arr_en);
        end
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (arr_en !== '0 || arr_act !== '0 || arr_w_wen !== '0 || arr_w_data !== '0 ||
            {busy, done, cmd_ready, act_ready} !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_clear: got en=%b act=%h wen=%h busy/done/cmd/act=%b want 0 and 0010",
                     arr_en, arr_act, arr_w_wen, {busy, done, cmd_ready, act_ready});
        end
        rstn = 1'b1;
        act_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || arr_en !== '0) begin
                errors++;
                $display("FAIL rstmid_quiet i=%0d: got done=%b busy=%b en=%b want 0", i, done, busy, arr_en);
            end
        end
        run_command(2, 1'b0, 0, 0, 1'b0, "rstmid_new");
    endtask

    task automatic test_back_to_back();
        run_command(2, 1'b0, 0, 0, 1'b1, "b2b_first");
        run_command(2, 1'b0, 0, 0, 1'b0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wt_gaps();
        test_act_gap();
        test_zero_rows();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmu_ctrl.md
MMU_CTRL -- requirements
Module: mmu_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning activation/weight element width.
REQ-002 SHALL have parameter ARRAY_DIM, default 4, meaning PE rows = PE columns of the driven array.
REQ-003 SHALL have parameter ROW_CNT_W, default 16, meaning width of the per-command activation row count.
REQ-004 SHALL use one clock and synchronous active-low reset. Ports: clk  in  1  clock (rising edge); rstn  in  1  synchronous active-low reset.
REQ-005 SHALL have ports: cmd_valid  in  1  command offered; cmd_ready  out  1  controller accepts command; cmd_num_rows  in  ROW_CNT_W  activation rows to stream.
REQ-006 SHALL have ports: wt_valid  in  1  weight row offered; wt_ready  out  1  weight row accepted; wt_data  in  ARRAY_DIM*DATA_WIDTH  one weight row, column c in slice c.
REQ-007 SHALL have ports: act_valid  in  1  activation vector offered; act_ready  out  1  vector accepted; act_data  in  ARRAY_DIM*DATA_WIDTH  one vector, row r in slice r.
REQ-008 SHALL have ports: arr_w_wen  out  ARRAY_DIM  per-column weight write enable; arr_w_data  out  ARRAY_DIM*DATA_WIDTH  top-edge weights; arr_en  out  ARRAY_DIM  per-row skewed enable; arr_act  out  ARRAY_DIM*DATA_WIDTH  left-edge skewed activations.
REQ-009 SHALL have ports: busy  out  1  not IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD_W, SETTLE, STREAM, DRAIN, DONE.
REQ-011 IDLE: cmd_ready=1; cmd_valid&cmd_ready latches cmd_num_rows, clears counters, goes LOAD_W next cycle.
REQ-012 LOAD_W: wt_ready=1; each wt_valid&wt_ready beat drives arr_w_wen all-ones and arr_w_data=wt_data the next cycle; after exactly ARRAY_DIM beats go SETTLE.
REQ-013 LOAD_W with wt_valid=0: arr_w_wen=0, arr_w_data=0, beat count held.
REQ-014 SETTLE: exactly ARRAY_DIM cycles, arr_en=0, arr_w_wen=0 (weight propagation and shadow-to-active promotion); then STREAM if latched rows>0, else DONE.
REQ-015 STREAM: act_ready=1; accepted vector enters skew; row r output delayed r cycles, arr_en[r] high exactly when row r carries an accepted element.
REQ-016 STREAM stall (act_valid=0): zero bubble enters the skew (en bit 0); skew keeps shifting; PEs hold state.
REQ-017 After the last of cmd_num_rows beats is accepted, go DRAIN; act_ready=0 outside STREAM.
REQ-018 DRAIN: exactly 2*ARRAY_DIM-1 cycles, bubbles shifted in; then DONE.
REQ-019 DONE: done=1 for one cycle, then IDLE; cmd_ready=0 in DONE (no back-to-back acceptance that cycle).
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Row counter SHALL be ROW_CNT_W bits, no wrap: max 2^ROW_CNT_W-1 rows per command.
REQ-022 arr_act slice r SHALL be 0 whenever arr_en[r]=0.
REQ-023 wt_valid/act_valid outside their states SHALL be ignored (ready low, no side effect).

Reset
REQ-024 rstn=0 at a clock edge SHALL force IDLE and zero counters, skew contents, arr_w_wen, arr_w_data, arr_en, arr_act, done, busy; cmd_ready=1 the first cycle after release.
REQ-025 Reset mid-operation SHALL discard the latched command and any in-flight skew data without emitting done.

Structure
REQ-026 Shared package mmu_pkg SHALL hold the FSM state enum and default DATA_WIDTH/ARRAY_DIM constants.
REQ-027 Per-row delay line SHALL be sub-module mmu_skew (parameters DEPTH, DATA_WIDTH; data+en in, delayed data+en out), instantiated per row with DEPTH=r (r=0 pass-through registered once).

Verification
REQ-028 Reset, then cmd num_rows=3, 4 weight rows back-to-back, acts always valid -> arr_w_wen=4'hF 4 cycles, SETTLE 4 cycles, arr_en[0] high 3 cycles, arr_en[3] same pattern 3 cycles later, done 7 cycles after last act beat.
REQ-029 wt_valid toggling 1/0 for 4 beats -> arr_w_wen pulses only on accepted beats, SETTLE starts after the 4th.
REQ-030 Acts with act_valid gap of 2 cycles mid-stream -> matching 2-cycle arr_en gap per row, shifted r cycles on row r; total accepted = num_rows.
REQ-031 num_rows=0 -> LOAD_W, SETTLE, DONE; arr_en never asserted; done pulses once.
REQ-032 rstn low during STREAM -> next cycle all arr_* zero, busy=0, no done; new command then completes normally.
REQ-033 cmd_valid held high through completion -> second command accepted only in IDLE, first cycle after DONE.
